// File: rtl/queue_reader_if.sv
// Bundle between queue_reader, the indexed queue's op port and the downstream stream.
// master is the reader side, slave is the queue/consumer side.
interface queue_reader_if #(
  parameter int DATA_SIZE = 64,
  parameter int PTR_WIDTH = 6
);
  logic [2:0]           q_op_flag;
  logic [PTR_WIDTH-1:0] q_op_index;
  logic [DATA_SIZE-1:0] q_op_data;
  logic [DATA_SIZE-1:0] q_pop_data;
  logic                 q_empty;
  logic                 q_error_time;
  logic                 m_valid;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_ready;

  modport master (
    output q_op_flag, q_op_index, q_op_data, m_valid, m_data,
    input  q_pop_data, q_empty, q_error_time, m_ready
  );

  modport slave (
    input  q_op_flag, q_op_index, q_op_data, m_valid, m_data,
    output q_pop_data, q_empty, q_error_time, m_ready
  );
endinterface

// File: rtl/queue_reader.sv
// Consumer-side engine for the indexed queue: pops entries, drops pops flagged by
// error_time, and streams the good ones in order through a small output FIFO.
module queue_reader #(
  parameter int         DATA_SIZE = 64,
  parameter int         FIFO_SIZE = 64,
  parameter int         PTR_WIDTH = $clog2(FIFO_SIZE),
  parameter int         OUT_DEPTH = 4,
  parameter int         RETRY_GAP = 2,
  parameter logic [2:0] OP_IDLE   = 3'b000,
  parameter logic [2:0] OP_POP    = 3'b101
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  queue_reader_if.master bus,
  output logic [31:0]   pop_count,
  output logic [15:0]   retry_count,
  output logic          busy
);

  localparam int AW    = $clog2(OUT_DEPTH);
  localparam int OCC_W = AW + 1;
  localparam int BO_W  = $clog2(RETRY_GAP + 1);
  localparam logic [OCC_W:0] DEPTH_LIM = OUT_DEPTH[OCC_W:0];
  localparam logic [BO_W-1:0] GAP_INIT = RETRY_GAP[BO_W-1:0];
  localparam logic [BO_W-1:0] GAP_ONE  = {{(BO_W-1){1'b0}}, 1'b1};

  typedef enum logic {RUN, BACKOFF} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t               state;
  logic [BO_W-1:0]      bo_cnt;
  logic                 cap_vld_p1;
  logic [DATA_SIZE-1:0] cap_data_p1;
  logic [DATA_SIZE-1:0] mem [OUT_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [OCC_W-1:0]     occ;

  logic                 issue;
  logic                 wr_en;
  logic                 rd_en;
  logic                 err_hit;
  logic                 fifo_nonempty;
  logic [OCC_W:0]       credit_used;

  // The in-flight capture holds a FIFO slot, so a pop is only allowed when both fit.
  assign credit_used   = {1'b0, occ} + {{OCC_W{1'b0}}, cap_vld_p1};
  assign err_hit       = cap_vld_p1 && bus.q_error_time;
  assign wr_en         = cap_vld_p1 && !bus.q_error_time;
  assign fifo_nonempty = (occ != '0);
  assign rd_en         = fifo_nonempty && bus.m_ready;

  assign issue = !reset && (state == RUN) && enable && !bus.q_empty &&
                 (credit_used < DEPTH_LIM) && !err_hit;

  assign bus.q_op_flag  = issue ? OP_POP : OP_IDLE;
  assign bus.q_op_index = '0;
  assign bus.q_op_data  = '0;
  assign bus.m_valid    = fifo_nonempty;
  assign bus.m_data     = fifo_nonempty ? mem[rd_ptr] : '0;
  assign busy           = cap_vld_p1 || fifo_nonempty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      bo_cnt      <= '0;
      cap_vld_p1  <= 1'b0;
      occ         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pop_count   <= '0;
      retry_count <= '0;
    end else begin
      cap_vld_p1 <= issue;

      unique case (state)
        RUN: begin
          if (err_hit) begin
            state  <= BACKOFF;
            bo_cnt <= GAP_INIT;
          end
        end
        BACKOFF: begin
          bo_cnt <= bo_cnt - GAP_ONE;
          if (bo_cnt <= GAP_ONE) state <= RUN;
        end
        default: state <= RUN;
      endcase

      if (wr_en) begin
        wr_ptr    <= wr_ptr + 1'b1;
        pop_count <= pop_count + 32'd1;
      end
      if (err_hit) retry_count <= sat_inc16(retry_count);
      if (rd_en)   rd_ptr <= rd_ptr + 1'b1;

      unique case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // p1: pop data captured the cycle after the pop; p2: entry lands in the output FIFO
  always_ff @(posedge clk) begin
    if (issue) cap_data_p1 <= bus.q_pop_data;
    if (wr_en) mem[wr_ptr] <= cap_data_p1;
  end

endmodule

// File: tb/tb_queue_reader.sv
// Directed bench for queue_reader against a small behavioural queue and
// hand-computed per-cycle expectations.
module tb_queue_reader;
  localparam int         DATA_SIZE = 64;
  localparam int         FIFO_SIZE = 64;
  localparam int         PTR_WIDTH = 6;
  localparam int         OUT_DEPTH = 4;
  localparam int         RETRY_GAP = 2;
  localparam logic [2:0] OP_IDLE   = 3'b000;
  localparam logic [2:0] OP_POP    = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] pop_count;
  logic [15:0] retry_count;
  logic        busy;

  queue_reader_if #(.DATA_SIZE(DATA_SIZE), .PTR_WIDTH(PTR_WIDTH)) qif ();

  queue_reader #(
    .DATA_SIZE(DATA_SIZE), .FIFO_SIZE(FIFO_SIZE), .PTR_WIDTH(PTR_WIDTH),
    .OUT_DEPTH(OUT_DEPTH), .RETRY_GAP(RETRY_GAP), .OP_IDLE(OP_IDLE), .OP_POP(OP_POP)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(qif),
    .pop_count(pop_count), .retry_count(retry_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural queue: combinational head data, head advances on each accepted pop.
  logic [63:0] qmem [0:63];
  int          qhead = 0;
  int          qtail = 0;
  logic        pop_pend = 1'b0;
  int          pops_seen = 0;
  logic [63:0] rcv [$];
  logic [63:0] expq [$];

  assign qif.q_empty    = (qhead == qtail);
  assign qif.q_pop_data = qmem[qhead % 64];

  always @(negedge clk) begin
    pop_pend = (qif.q_op_flag == OP_POP);
    if (pop_pend) pops_seen = pops_seen + 1;
    if (qif.m_valid && qif.m_ready) rcv.push_back(qif.m_data);
  end

  always @(posedge clk) if (pop_pend) qhead <= qhead + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input bit good);
    qmem[qtail % 64] = d;
    qtail++;
    if (good) expq.push_back(d);
  endtask

  task automatic wait_rcv(input int n, input string tag);
    for (int i = 0; i < 200 && rcv.size() < n; i++) tick();
    chk(tag, 64'(rcv.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int max_infl;
    int infl;

    reset = 1'b1;
    enable = 1'b1;
    qif.m_ready = 1'b1;
    qif.q_error_time = 1'b0;
    push(64'hAAAA_0000_0000_000A, 1);
    push(64'hBBBB_0000_0000_000B, 1);
    push(64'hCCCC_0000_0000_000C, 1);

    // Reset held two cycles with a non-empty queue and enable high
    tick();
    chk("rst_flag0", 64'(qif.q_op_flag), 64'(OP_IDLE));
    chk("rst_mvalid", 64'(qif.m_valid), 64'd0);
    chk("rst_popcnt", 64'(pop_count), 64'd0);
    chk("rst_retry", 64'(retry_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mdata", qif.m_data, 64'd0);
    tick();
    chk("rst_flag1", 64'(qif.q_op_flag), 64'(OP_IDLE));
    chk("tied_index", 64'(qif.q_op_index), 64'd0);
    chk("tied_data", qif.q_op_data, 64'd0);

    // Streaming A,B,C
    reset = 1'b0;
    #1;
    chk("s_c0_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    tick();
    chk("s_c1_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    chk("s_c1_mvalid", 64'(qif.m_valid), 64'd0);
    tick();
    chk("s_c2_mvalid", 64'(qif.m_valid), 64'd1);
    chk("s_c2_mdata", qif.m_data, 64'hAAAA_0000_0000_000A);
    chk("s_c2_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    tick();
    chk("s_c3_mdata", qif.m_data, 64'hBBBB_0000_0000_000B);
    chk("s_c3_idle", 64'(qif.q_op_flag), 64'(OP_IDLE));
    tick();
    chk("s_c4_mdata", qif.m_data, 64'hCCCC_0000_0000_000C);
    tick();
    chk("s_c5_mvalid", 64'(qif.m_valid), 64'd0);
    chk("s_popcnt", 64'(pop_count), 64'd3);
    chk("s_busy", 64'(busy), 64'd0);

    // Backpressure: 10 entries, sink stalled
    qif.m_ready = 1'b0;
    p0 = pops_seen;
    for (int i = 0; i < 10; i++) push(64'hB000_0000_0000_0000 + 64'(i), 1);
    for (int i = 0; i < 12; i++) tick();
    chk("bp_pops", 64'(pops_seen - p0), 64'd4);
    chk("bp_idle", 64'(qif.q_op_flag), 64'(OP_IDLE));
    chk("bp_mvalid", 64'(qif.m_valid), 64'd1);
    chk("bp_head", qif.m_data, 64'hB000_0000_0000_0000);
    chk("bp_popcnt", 64'(pop_count), 64'd7);
    qif.m_ready = 1'b1;
    max_infl = 0;
    for (int i = 0; i < 200 && rcv.size() < 13; i++) begin
      tick();
      infl = (pops_seen - p0) - (rcv.size() - 3);
      if (infl > max_infl) max_infl = infl;
    end
    chk("bp_count", 64'(rcv.size()), 64'd13);
    chk("bp_maxocc", 64'(max_infl <= OUT_DEPTH), 64'd1);
    chk("bp_popcnt2", 64'(pop_count), 64'd13);

    // Retry: error_time flagged on the capture of the second pop
    push(64'hD000_0000_0000_0000, 1);
    push(64'hD000_0000_0000_0001, 0);
    push(64'hD000_0000_0000_0002, 1);
    push(64'hD000_0000_0000_0003, 1);
    #1;
    chk("r_c0_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    tick();
    chk("r_c1_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    tick();
    qif.q_error_time = 1'b1;
    #1;
    chk("r_E_idle", 64'(qif.q_op_flag), 64'(OP_IDLE));
    tick();
    qif.q_error_time = 1'b0;
    #1;
    chk("r_E1_idle", 64'(qif.q_op_flag), 64'(OP_IDLE));
    chk("r_retry", 64'(retry_count), 64'd1);
    tick();
    chk("r_E2_idle", 64'(qif.q_op_flag), 64'(OP_IDLE));
    tick();
    chk("r_E3_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    wait_rcv(16, "r_count");
    chk("r_popcnt", 64'(pop_count), 64'd16);
    chk("r_retry2", 64'(retry_count), 64'd1);

    // Enable drop right after a pop
    push(64'hF000_0000_0000_0000, 1);
    push(64'hF000_0000_0000_0001, 1);
    push(64'hF000_0000_0000_0002, 1);
    #1;
    chk("e_c0_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    tick();
    enable = 1'b0;
    #1;
    chk("e_c1_idle", 64'(qif.q_op_flag), 64'(OP_IDLE));
    tick();
    chk("e_c2_mvalid", 64'(qif.m_valid), 64'd1);
    chk("e_c2_mdata", qif.m_data, 64'hF000_0000_0000_0000);
    chk("e_c2_idle", 64'(qif.q_op_flag), 64'(OP_IDLE));
    tick();
    chk("e_c3_idle", 64'(qif.q_op_flag), 64'(OP_IDLE));
    chk("e_c3_mvalid", 64'(qif.m_valid), 64'd0);
    tick();
    enable = 1'b1;
    #1;
    chk("e_c4_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    wait_rcv(19, "e_count");
    chk("e_popcnt", 64'(pop_count), 64'd19);

    // Reset with occ=3 and a capture in flight
    qif.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(64'h6000_0000_0000_0000 + 64'(i), i >= 4);
    #1;
    chk("m_c0_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    tick();
    tick();
    tick();
    chk("m_c3_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    tick();
    chk("m_c4_idle", 64'(qif.q_op_flag), 64'(OP_IDLE));
    chk("m_c4_busy", 64'(busy), 64'd1);
    chk("m_c4_popcnt", 64'(pop_count), 64'd22);
    reset = 1'b1;
    #1;
    chk("m_rst_idle", 64'(qif.q_op_flag), 64'(OP_IDLE));
    tick();
    reset = 1'b0;
    #1;
    chk("m_mvalid", 64'(qif.m_valid), 64'd0);
    chk("m_busy", 64'(busy), 64'd0);
    chk("m_popcnt", 64'(pop_count), 64'd0);
    chk("m_retry", 64'(retry_count), 64'd0);
    chk("m_pop", 64'(qif.q_op_flag), 64'(OP_POP));
    qif.m_ready = 1'b1;
    wait_rcv(21, "m_count");
    chk("m_popcnt2", 64'(pop_count), 64'd2);

    // Delivered stream against the list of good pops
    chk("order_len", 64'(rcv.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < rcv.size(); i++)
      chk($sformatf("order_%0d", i), rcv[i], expq[i]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/queue_reader.md
Name: queue_reader

Overview:
Consumer-side engine for the indexed queue. It issues pop commands on the queue's op interface and captures pop_data. It then uses error_time to separate good pops from premature ones (head scan not finished). Good entries go through an OUT_DEPTH output FIFO to a valid/ready downstream stream. It sits between the queue and any consumer that needs a clean in-order stream without handling queue timing hazards.

Parameters:
DATA_SIZE, 64, entry width
FIFO_SIZE, 64, queue depth (power of 2)
PTR_WIDTH, $clog2(FIFO_SIZE), queue op_index width
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)
RETRY_GAP, 2, extra idle cycles after an error_time (>=1)
OP_IDLE, 3'b000, queue idle opcode
OP_POP, 3'b101, queue pop opcode

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  allow new pops
q_op_flag  out  3  queue opcode, OP_POP or OP_IDLE
q_op_index  out  PTR_WIDTH  tied 0
q_op_data  out  DATA_SIZE  tied 0
q_pop_data  in  DATA_SIZE  queue combinational pop data
q_empty  in  1  queue empty
q_error_time  in  1  queue registered error_time
m_valid  out  1  output stream valid
m_data  out  DATA_SIZE  output stream data
m_ready  in  1  downstream ready
pop_count  out  32  good pops delivered into the output FIFO; wraps modulo 2^32
retry_count  out  16  discarded pops; saturates at 16'hFFFF
busy  out  1  cap_vld or output FIFO non-empty

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset state: q_op_flag=OP_IDLE, m_valid=0, m_data=0, pop_count=0, retry_count=0, busy=0, cap_vld=0, output FIFO occupancy occ=0, state=RUN, backoff counter=0.
- States: RUN and BACKOFF.
- issue (combinational) = state==RUN && enable && !q_empty && (occ + cap_vld < OUT_DEPTH) && !(cap_vld && q_error_time).
- q_op_flag = issue ? OP_POP : OP_IDLE. At most one pop per cycle; back-to-back pops are allowed.
- Pop issued in cycle N: q_pop_data is registered into cap_data at the end of N, and cap_vld=1 during N+1.
- Cycle N+1 with cap_vld=1 and q_error_time=0: cap_data is written to the output FIFO at the end of N+1 and pop_count increments. m_valid rises in N+2 if the FIFO was empty, so pop-to-m_valid latency is 2 cycles.
- Cycle N+1 with cap_vld=1 and q_error_time=1:
  - cap_data is discarded and retry_count increments (saturating).
  - No pop is issued in N+1.
  - state goes to BACKOFF with counter=RETRY_GAP.
  - BACKOFF decrements the counter each cycle and returns to RUN when it reaches 1. The earliest next pop is therefore N+1+RETRY_GAP+1.
- cap_vld clears in any cycle without a new issue. q_error_time is only sampled when cap_vld=1, because it is stale otherwise.
- Output FIFO:
  - m_valid = (occ!=0); m_data = oldest entry, and 0 when empty.
  - A transfer occurs when m_valid && m_ready.
  - A simultaneous write and read in one cycle keeps occ unchanged.
  - Read/write pointers wrap modulo OUT_DEPTH.
  - Credit rule: an in-flight capture always reserves one slot, so the output FIFO never overflows.
- enable low: no new pops. An in-flight capture still completes, and the output FIFO keeps draining.
- BACKOFF ignores enable toggling and still counts down.
- Reset mid-operation: takes effect at the next edge and discards the in-flight capture and all FIFO contents. No pop is issued in the cycle reset is high.
- Order is preserved: m_data order equals the order of good pops.

Test Plan:
- Reset: hold reset 2 cycles with q_empty=0 and enable=1 -> q_op_flag=OP_IDLE during reset, m_valid=0, pop_count=0, retry_count=0, busy=0.
- Streaming: queue holds A,B,C; enable=1, m_ready=1; pops at cycles 0,1,2 -> m_data=A,B,C valid at cycles 2,3,4; pop_count=3; q_op_flag=OP_IDLE from cycle 3 once q_empty=1.
- Backpressure: OUT_DEPTH=4, 10 entries, m_ready=0 -> exactly 4 pops issued, then OP_IDLE held. Raise m_ready -> all 10 entries delivered in order; occ never exceeds 4.
- Retry: q_error_time=1 in the cycle after the 2nd pop (cycle E) -> 2nd datum never appears on m_data; retry_count=1; no pops in E..E+2; next pop at E+3 with RETRY_GAP=2.
- Enable drop: deassert enable in the cycle after a pop -> that datum is still delivered and no further OP_POP appears; reassert -> pops resume next cycle.
- Reset mid-stream with occ=3 and cap_vld=1 -> next cycle m_valid=0, busy=0, counters 0, and the first post-reset datum is the next queue entry.
